// File: rtl/fifo_burst_reader.sv
// Read-domain burst consumer: pops a commanded number of words from a
// first-word-fall-through FIFO and streams them out through a 2-entry skid buffer.

module fifo_burst_skid #(
  parameter int W = 8
) (
  input  logic         rclk,
  input  logic         rst_i,
  input  logic         flush_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] head_o,
  output logic [1:0]   occ_o,
  output logic [1:0]   occ_nxt_o
);
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic [1:0]   occ_q, occ_d;

  // e0 is always the head, so m_data only moves on a pop or a push into empty.
  always_comb begin
    occ_d = occ_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    if (flush_i) begin
      occ_d = 2'd0;
    end else begin
      case ({push_i, pop_i})
        2'b10: begin
          if (occ_q == 2'd0) e0_d = din_i;
          else               e1_d = din_i;
          occ_d = occ_q + 2'd1;
        end
        2'b01: begin
          e0_d  = e1_q;
          occ_d = occ_q - 2'd1;
        end
        2'b11: begin
          if (occ_q == 2'd1) begin
            e0_d = din_i;
          end else begin
            e0_d = e1_q;
            e1_d = din_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge rclk) begin
    if (rst_i) begin
      occ_q <= 2'd0;
      e0_q  <= '0;
      e1_q  <= '0;
    end else begin
      occ_q <= occ_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
    end
  end

  assign head_o    = e0_q;
  assign occ_o     = occ_q;
  assign occ_nxt_o = occ_d;
endmodule

module fifo_burst_reader #(
  parameter int DATASIZE = 8,
  parameter int ADDRSIZE = 9
) (
  input  logic                rclk,
  input  logic                r_rst,
  input  logic                start,
  input  logic [ADDRSIZE:0]   burst_len,
  input  logic                abort,
  input  logic [DATASIZE-1:0] rdata,
  input  logic                rempty,
  output logic                rinc,
  output logic [DATASIZE-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                busy,
  output logic                done,
  output logic                aborted,
  output logic [ADDRSIZE:0]   words_read,
  output logic [15:0]         stall_cycles
);
  localparam int LW = ADDRSIZE + 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d, wr_q, wr_d;
  logic [15:0]   stall_q, stall_d;
  logic          abt_q, abt_d;
  logic [1:0]    occ, occ_nxt;
  logic          pop_out, space, kill;

  assign pop_out = m_valid && m_ready;
  // A full buffer still has room when its head leaves this same cycle.
  assign space   = (occ < 2'd2) || pop_out;
  assign kill    = abort && ((state_q == RUN) || (state_q == DRAIN));
  assign rinc    = (state_q == RUN) && !kill && !rempty && (rem_q != '0) && space;

  fifo_burst_skid #(.W(DATASIZE)) u_skid (
    .rclk      (rclk),
    .rst_i     (r_rst),
    .flush_i   (kill),
    .push_i    (rinc),
    .pop_i     (pop_out),
    .din_i     (rdata),
    .head_o    (m_data),
    .occ_o     (occ),
    .occ_nxt_o (occ_nxt)
  );

  assign m_valid = (occ != 2'd0);

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    wr_d    = wr_q;
    stall_d = stall_q;
    abt_d   = abt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = burst_len;
          wr_d    = '0;
          stall_d = '0;
          abt_d   = 1'b0;
          state_d = (burst_len != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (rempty && (rem_q != '0) && (stall_q != 16'hFFFF)) stall_d = stall_q + 16'd1;
        if (kill) begin
          abt_d   = 1'b1;
          rem_d   = '0;
          state_d = DONE;
        end else begin
          if (rinc) begin
            rem_d = rem_q - 1'b1;
            wr_d  = wr_q + 1'b1;
          end
          if (rem_d == '0) state_d = (occ_nxt != 2'd0) ? DRAIN : DONE;
        end
      end
      DRAIN: begin
        if (kill) begin
          abt_d   = 1'b1;
          state_d = DONE;
        end else if (occ_nxt == 2'd0) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge rclk) begin
    if (r_rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wr_q    <= '0;
      stall_q <= '0;
      abt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wr_q    <= wr_d;
      stall_q <= stall_d;
      abt_q   <= abt_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign aborted      = abt_q;
  assign words_read   = wr_q;
  assign stall_cycles = stall_q;
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: queue-based FWFT FIFO model, stream scoreboard
// and per-scenario tasks with randomized data and backpressure.

module tb_fifo_burst_reader;
  localparam int DS = 8;
  localparam int AS = 9;
  localparam int LW = AS + 1;

  logic          rclk = 1'b0;
  logic          r_rst, start, abort, rempty, rinc, m_valid, m_ready;
  logic          busy, done, aborted;
  logic [LW-1:0] burst_len, words_read;
  logic [DS-1:0] rdata, m_data;
  logic [15:0]   stall_cycles;

  always #5 rclk = ~rclk;

  fifo_burst_reader #(.DATASIZE(DS), .ADDRSIZE(AS)) dut (
    .rclk(rclk), .r_rst(r_rst), .start(start), .burst_len(burst_len), .abort(abort),
    .rdata(rdata), .rempty(rempty), .rinc(rinc), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .busy(busy), .done(done), .aborted(aborted),
    .words_read(words_read), .stall_cycles(stall_cycles)
  );

  int n_vec, n_err;
  logic [DS-1:0] fq[$];
  logic [DS-1:0] got[$];
  logic [DS-1:0] w[$];
  int cyc, n_rinc, n_bad_rinc, n_done, n_unstable, burst_pops, cur_len, stall_exp;
  int first_rinc, last_rinc, done_cyc, last_acc;
  logic          s_rinc, s_mvalid, s_done, s_busy, s_aborted;
  logic [DS-1:0] s_mdata;
  logic [LW-1:0] s_words;
  logic [15:0]   s_stall;
  logic          p_hold;
  logic [DS-1:0] p_data;

  function automatic void refresh();
    rempty = (fq.size() == 0);
    rdata  = (fq.size() != 0) ? fq[0] : DS'($urandom);
  endfunction

  function automatic void clear_stats();
    got.delete();
    cyc = 0; n_rinc = 0; n_bad_rinc = 0; n_done = 0; n_unstable = 0;
    burst_pops = 0; stall_exp = 0;
    first_rinc = -1; last_rinc = -1; done_cyc = -1; last_acc = -1;
  endfunction

  // One clock: snapshot at negedge, FIFO model pops just after posedge.
  task automatic step();
    @(negedge rclk);
    s_rinc = rinc; s_mvalid = m_valid; s_mdata = m_data; s_done = done;
    s_busy = busy; s_aborted = aborted; s_words = words_read; s_stall = stall_cycles;
    if (rinc) begin
      n_rinc++; burst_pops++;
      if (first_rinc < 0) first_rinc = cyc;
      last_rinc = cyc;
      if (rempty) n_bad_rinc++;
    end
    if (m_valid && m_ready) begin got.push_back(m_data); last_acc = cyc; end
    if (m_valid && p_hold && (m_data !== p_data)) n_unstable++;
    p_hold = m_valid && !m_ready;
    p_data = m_data;
    if (done) begin n_done++; done_cyc = cyc; end
    // RUN cycle with the FIFO empty and words still owed
    if (busy && rempty && (burst_pops < cur_len)) stall_exp++;
    cyc++;
    @(posedge rclk); #1;
    if (s_rinc && fq.size() != 0) fq.delete(0);
    refresh();
  endtask

  task automatic begin_burst(input int len);
    clear_stats();
    cur_len   = len;
    burst_len = LW'(len);
    start     = 1'b1;
    step();
    start     = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = s_done;
    end
  endtask

  function automatic bit stream_ok(input int limit);
    int n;
    n = (limit < w.size()) ? limit : w.size();
    if (got.size() != n) return 1'b0;
    foreach (got[i]) if (got[i] !== w[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic test_reset();
    r_rst = 1'b1; start = 1'b0; abort = 1'b0; m_ready = 1'b0; burst_len = '0;
    fq.delete(); fq.push_back(8'hAA); refresh();
    p_hold = 1'b0;
    cur_len = 0;
    clear_stats();
    step(); step();
    r_rst = 1'b0;
    step();
    n_vec++; if (s_rinc !== 1'b0)    begin n_err++; $display("FAIL reset_rinc got=%b exp=0", s_rinc); end
    n_vec++; if (s_mvalid !== 1'b0)  begin n_err++; $display("FAIL reset_mvalid got=%b exp=0", s_mvalid); end
    n_vec++; if (s_busy !== 1'b0)    begin n_err++; $display("FAIL reset_busy got=%b exp=0", s_busy); end
    n_vec++; if (s_done !== 1'b0)    begin n_err++; $display("FAIL reset_done got=%b exp=0", s_done); end
    n_vec++; if (s_aborted !== 1'b0) begin n_err++; $display("FAIL reset_aborted got=%b exp=0", s_aborted); end
    n_vec++; if (s_words !== '0)     begin n_err++; $display("FAIL reset_words got=%0d exp=0", s_words); end
    n_vec++; if (s_stall !== '0)     begin n_err++; $display("FAIL reset_stall got=%0d exp=0", s_stall); end
    n_vec++; if (s_mdata !== '0)     begin n_err++; $display("FAIL reset_mdata got=%h exp=00", s_mdata); end
    fq.delete(); refresh();
  endtask

  task automatic test_basic();
    bit ok;
    w.delete();
    for (int i = 0; i < 8; i++) w.push_back(DS'(8'h10 + i));
    fq = w; refresh();
    m_ready = 1'b1;
    begin_burst(8);
    wait_done(40, ok);
    n_vec++; if (!ok)                  begin n_err++; $display("FAIL basic_timeout got=no_done exp=done"); end
    n_vec++; if (n_rinc != 8)          begin n_err++; $display("FAIL basic_pops got=%0d exp=8", n_rinc); end
    n_vec++; if (first_rinc != 1 || last_rinc != 8) begin
      n_err++; $display("FAIL basic_rinc_window got=%0d..%0d exp=1..8", first_rinc, last_rinc); end
    n_vec++; if (!stream_ok(8))        begin n_err++; $display("FAIL basic_stream got=%0d words exp=8 in order", got.size()); end
    n_vec++; if (done_cyc != last_acc + 1) begin n_err++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, last_acc + 1); end
    n_vec++; if (s_words !== LW'(8))   begin n_err++; $display("FAIL basic_words got=%0d exp=8", s_words); end
    n_vec++; if (s_stall !== 16'd0)    begin n_err++; $display("FAIL basic_stall got=%0d exp=0", s_stall); end
    step();
    n_vec++; if (s_busy !== 1'b0 || n_done != 1) begin
      n_err++; $display("FAIL basic_idle got=busy%b/done%0d exp=busy0/done1", s_busy, n_done); end
  endtask

  task automatic test_backpressure();
    bit ok;
    w.delete();
    for (int i = 0; i < 4; i++) w.push_back(DS'($urandom));
    fq = w; refresh();
    m_ready = 1'b0;
    begin_burst(4);
    repeat (10) step();
    n_vec++; if (n_rinc != 2)       begin n_err++; $display("FAIL bp_pops got=%0d exp=2", n_rinc); end
    n_vec++; if (s_rinc !== 1'b0)   begin n_err++; $display("FAIL bp_rinc got=%b exp=0", s_rinc); end
    n_vec++; if (s_mvalid !== 1'b1 || s_mdata !== w[0]) begin
      n_err++; $display("FAIL bp_head got=%b/%h exp=1/%h", s_mvalid, s_mdata, w[0]); end
    m_ready = 1'b1;
    wait_done(30, ok);
    n_vec++; if (!ok)                begin n_err++; $display("FAIL bp_timeout got=no_done exp=done"); end
    n_vec++; if (n_unstable != 0)    begin n_err++; $display("FAIL bp_stable got=%0d changes exp=0", n_unstable); end
    n_vec++; if (!stream_ok(4))      begin n_err++; $display("FAIL bp_stream got=%0d words exp=4 in order", got.size()); end
    n_vec++; if (s_words !== LW'(4)) begin n_err++; $display("FAIL bp_words got=%0d exp=4", s_words); end
  endtask

  task automatic test_stall();
    bit ok;
    w.delete();
    for (int i = 0; i < 6; i++) w.push_back(DS'($urandom));
    fq.delete();
    for (int i = 0; i < 3; i++) fq.push_back(w[i]);
    refresh();
    m_ready = 1'b1;
    begin_burst(6);
    repeat (8) step();
    for (int i = 3; i < 6; i++) fq.push_back(w[i]);
    refresh();
    wait_done(40, ok);
    n_vec++; if (!ok)                 begin n_err++; $display("FAIL stall_timeout got=no_done exp=done"); end
    n_vec++; if (n_bad_rinc != 0)     begin n_err++; $display("FAIL stall_rinc_empty got=%0d exp=0", n_bad_rinc); end
    // pops in cycles 1..3, FIFO empty for cycles 4..8
    n_vec++; if (s_stall !== 16'd5)   begin n_err++; $display("FAIL stall_count got=%0d exp=5", s_stall); end
    n_vec++; if (!stream_ok(6))       begin n_err++; $display("FAIL stall_stream got=%0d words exp=6 in order", got.size()); end
    step();
    n_vec++; if (n_done != 1)         begin n_err++; $display("FAIL stall_done got=%0d pulses exp=1", n_done); end
  endtask

  task automatic test_abort();
    w.delete();
    for (int i = 0; i < 100; i++) w.push_back(DS'($urandom));
    fq = w; refresh();
    m_ready = 1'b1;
    begin_burst(100);
    for (int i = 0; i < 60 && n_rinc < 20; i++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    n_vec++; if (s_rinc !== 1'b0 || n_rinc != 20) begin
      n_err++; $display("FAIL abort_rinc got=%b/%0d exp=0/20", s_rinc, n_rinc); end
    step();
    n_vec++; if (s_mvalid !== 1'b0)  begin n_err++; $display("FAIL abort_flush got=%b exp=0", s_mvalid); end
    n_vec++; if (s_done !== 1'b1)    begin n_err++; $display("FAIL abort_done got=%b exp=1", s_done); end
    n_vec++; if (s_aborted !== 1'b1) begin n_err++; $display("FAIL abort_flag got=%b exp=1", s_aborted); end
    n_vec++; if (s_words !== LW'(20)) begin n_err++; $display("FAIL abort_words got=%0d exp=20", s_words); end
    step();
    n_vec++; if (s_busy !== 1'b0 || s_aborted !== 1'b1 || n_done != 1) begin
      n_err++; $display("FAIL abort_after got=busy%b/ab%b/done%0d exp=busy0/ab1/done1", s_busy, s_aborted, n_done); end
    n_vec++; if (got.size() > 20 || !stream_ok(got.size())) begin
      n_err++; $display("FAIL abort_stream got=%0d words exp=ordered prefix of 20", got.size()); end
    fq.delete(); refresh();
  endtask

  task automatic test_zero_len();
    fq.delete(); fq.push_back(8'h5A); fq.push_back(8'hA5); refresh();
    m_ready = 1'b1;
    begin_burst(0);
    step();
    n_vec++; if (s_busy !== 1'b1 || s_done !== 1'b1) begin
      n_err++; $display("FAIL zero_done got=busy%b/done%b exp=1/1", s_busy, s_done); end
    step();
    n_vec++; if (s_busy !== 1'b0 || s_done !== 1'b0) begin
      n_err++; $display("FAIL zero_idle got=busy%b/done%b exp=0/0", s_busy, s_done); end
    n_vec++; if (n_rinc != 0 || s_words !== '0) begin
      n_err++; $display("FAIL zero_pops got=%0d/%0d exp=0/0", n_rinc, s_words); end
    fq.delete(); refresh();
  endtask

  task automatic test_reset_mid();
    bit ok;
    w.delete();
    for (int i = 0; i < 6; i++) w.push_back(DS'($urandom));
    fq = w; refresh();
    m_ready = 1'b0;
    begin_burst(6);
    repeat (4) step();
    n_vec++; if (s_mvalid !== 1'b1 || n_rinc != 2) begin
      n_err++; $display("FAIL rmid_full got=%b/%0d exp=1/2", s_mvalid, n_rinc); end
    r_rst = 1'b1;
    step();
    r_rst = 1'b0;
    step();
    n_vec++; if (s_busy !== 1'b0 || s_mvalid !== 1'b0 || s_rinc !== 1'b0 || s_done !== 1'b0) begin
      n_err++; $display("FAIL rmid_ctrl got=b%b v%b r%b d%b exp=0000", s_busy, s_mvalid, s_rinc, s_done); end
    n_vec++; if (s_words !== '0 || s_stall !== '0 || s_mdata !== '0 || s_aborted !== 1'b0) begin
      n_err++; $display("FAIL rmid_regs got=%0d/%0d/%h/%b exp=0/0/00/0", s_words, s_stall, s_mdata, s_aborted); end
    n_vec++; if (n_done != 0) begin n_err++; $display("FAIL rmid_nodone got=%0d exp=0", n_done); end
    w.delete();
    for (int i = 0; i < 5; i++) w.push_back(DS'($urandom));
    fq = w; refresh();
    m_ready = 1'b1;
    begin_burst(5);
    wait_done(30, ok);
    n_vec++; if (!ok || !stream_ok(5) || s_words !== LW'(5)) begin
      n_err++; $display("FAIL rmid_restart got=done%b/%0d words exp=done1/5", ok, got.size()); end
  endtask

  task automatic test_random();
    bit ok;
    int len, pushed, budget;
    for (int b = 0; b < 6; b++) begin
      len = (b == 0) ? 300 : int'($urandom_range(1, 40));
      w.delete();
      for (int i = 0; i < len; i++) w.push_back(DS'($urandom));
      fq.delete(); refresh();
      pushed = 0;
      m_ready = 1'b1;
      begin_burst(len);
      ok = 1'b0;
      budget = len * 8 + 100;
      for (int c = 0; c < budget && !ok; c++) begin
        if (pushed < len && ($urandom % 2) == 0) begin fq.push_back(w[pushed]); pushed++; refresh(); end
        m_ready = (($urandom % 4) != 0);
        step();
        ok = s_done;
      end
      n_vec++; if (!ok) begin n_err++; $display("FAIL rnd%0d_timeout got=no_done exp=done", b); end
      n_vec++; if (!stream_ok(len)) begin n_err++; $display("FAIL rnd%0d_stream got=%0d words exp=%0d in order", b, got.size(), len); end
      n_vec++; if (s_words !== LW'(len)) begin n_err++; $display("FAIL rnd%0d_words got=%0d exp=%0d", b, s_words, len); end
      n_vec++; if (s_stall !== 16'(stall_exp)) begin n_err++; $display("FAIL rnd%0d_stall got=%0d exp=%0d", b, s_stall, stall_exp); end
      n_vec++; if (n_bad_rinc != 0 || n_unstable != 0) begin
        n_err++; $display("FAIL rnd%0d_proto got=%0d/%0d exp=0/0", b, n_bad_rinc, n_unstable); end
      n_vec++; if (n_done != 1 || s_aborted !== 1'b0) begin
        n_err++; $display("FAIL rnd%0d_done got=%0d/%b exp=1/0", b, n_done, s_aborted); end
      step();
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    test_reset();
    test_basic();
    test_backpressure();
    test_stall();
    test_abort();
    test_zero_len();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
